debounce_multi: RTL and testbench



---
 rtl/debounce_pkg.sv | 28 ++
 rtl/debounce_channel.sv | 135 +++++++++++++
 rtl/debounce_multi.sv | 43 ++++
 tb/tb_debounce_multi.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debounce_pkg
// Description : Shared types and helpers for the multi-channel button
//               conditioner: channel state encoding and counter sizing.
// Revision    : 1.0 - initial release
// ============================================================================
package debounce_pkg;

  // Per-channel debounce state; the level is "pressed" in the upper two.
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    PRESSED    = 2'd2,
    RELEASE_DB = 2'd3
  } chan_state_e;

  // Bits needed to hold values 0..max_val; never narrower than one bit so
  // a disabled counter still has a legal declaration.
  function automatic int cnt_width(input int unsigned max_val);
    if (max_val < 1) begin
      return 1;
    end
    return $clog2(max_val + 1);
  endfunction

endpackage : debounce_pkg
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
// Module      : debounce_channel
// Description : One button channel: two-flop synchroniser, counter-based
//               press/release debouncer and long-hold detector. All outputs
//               are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned DELAY_COUNTS      = 2500,
  parameter int unsigned LONG_PRESS_COUNTS = 25000000,
  parameter bit          ACTIVE_LOW        = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button_i,
  output logic state_o,
  output logic pressed_o,
  output logic released_o,
  output logic held_o
);

  localparam int CNT_W  = cnt_width(DELAY_COUNTS);
  localparam int HOLD_W = cnt_width(LONG_PRESS_COUNTS);

  // Last debounce count before a level change is accepted.
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DELAY_COUNTS - 1);
  // Hold counter saturates here and therefore never revisits HOLD_LAST.
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_COUNTS);
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    HOLD_W'((LONG_PRESS_COUNTS > 0) ? (LONG_PRESS_COUNTS - 1) : 0);
  localparam bit                HOLD_EN   = (LONG_PRESS_COUNTS > 0);

  logic              sync_meta_q;
  logic              sync_q;
  logic              act;
  chan_state_e       state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_d;
  logic              held_hit;
  logic              level_q;
  logic              pressed_q;
  logic              released_q;
  logic              held_q;

  // Two-flop synchroniser; reset loads the idle (not pressed) raw level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta_q <= ACTIVE_LOW;
      sync_q      <= ACTIVE_LOW;
    end else begin
      sync_meta_q <= button_i;
      sync_q      <= sync_meta_q;
    end
  end

  // Normalised input: 1 means pressed regardless of board polarity.
  assign act = sync_q ^ ACTIVE_LOW;

  // Saturating hold count and the single crossing of the long-press mark.
  assign hold_d   = (hold_q == HOLD_MAX) ? hold_q : (hold_q + 1'b1);
  assign held_hit = HOLD_EN && (hold_q == HOLD_LAST);

  // Debounce FSM with its counters and registered level/event outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hold_q     <= '0;
      level_q    <= 1'b0;
      pressed_q  <= 1'b0;
      released_q <= 1'b0;
      held_q     <= 1'b0;
    end else begin
      pressed_q  <= 1'b0;
      released_q <= 1'b0;
      held_q     <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (act) begin
            state_q <= PRESS_DB;
            cnt_q   <= '0;
          end
        end
        PRESS_DB: begin
          if (!act) begin
            state_q <= IDLE;
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= PRESSED;
            hold_q    <= '0;
            level_q   <= 1'b1;
            pressed_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        PRESSED: begin
          hold_q <= hold_d;
          held_q <= held_hit;
          if (!act) begin
            state_q <= RELEASE_DB;
            cnt_q   <= '0;
          end
        end
        RELEASE_DB: begin
          // Hold time keeps running through a release bounce.
          hold_q <= hold_d;
          held_q <= held_hit;
          if (act) begin
            state_q <= PRESSED;
          end else if (cnt_q == CNT_LAST) begin
            state_q    <= IDLE;
            level_q    <= 1'b0;
            released_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign state_o    = level_q;
  assign pressed_o  = pressed_q;
  assign released_o = released_q;
  assign held_o     = held_q;

endmodule : debounce_channel
`default_nettype wire

// File: rtl/debounce_multi.sv
`default_nettype none
// ============================================================================
// Module      : debounce_multi
// Description : N independent button conditioners. Raw board inputs in,
//               debounced level plus press/release/long-hold strobes out.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int unsigned N_BUTTONS         = 4,
  parameter int unsigned DELAY_COUNTS      = 2500,
  parameter int unsigned LONG_PRESS_COUNTS = 25000000,
  parameter bit          ACTIVE_LOW        = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_BUTTONS-1:0] button,
  output logic [N_BUTTONS-1:0] button_state,
  output logic [N_BUTTONS-1:0] button_pressed,
  output logic [N_BUTTONS-1:0] button_released,
  output logic [N_BUTTONS-1:0] button_held
);

  // One fully independent conditioner per button.
  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_chan
    debounce_channel #(
      .DELAY_COUNTS      (DELAY_COUNTS),
      .LONG_PRESS_COUNTS (LONG_PRESS_COUNTS),
      .ACTIVE_LOW        (ACTIVE_LOW)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .button_i   (button[i]),
      .state_o    (button_state[i]),
      .pressed_o  (button_pressed[i]),
      .released_o (button_released[i]),
      .held_o     (button_held[i])
    );
  end

endmodule : debounce_multi
`default_nettype wire

// File: tb/tb_debounce_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_debounce_multi
// Description : Scoreboard bench for debounce_multi. A cycle-level reference
//               model (run-length debouncing, age-since-press) queues the
//               expected outputs for every edge; a monitor compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debounce_multi;

  localparam int NB = 4;
  localparam int D  = 4;
  localparam int L  = 10;

  logic          clk;
  logic          rst_n;
  logic [NB-1:0] button;
  logic [NB-1:0] button_state;
  logic [NB-1:0] button_pressed;
  logic [NB-1:0] button_released;
  logic [NB-1:0] button_held;

  int checks;
  int errors;

  debounce_multi #(
    .N_BUTTONS         (NB),
    .DELAY_COUNTS      (D),
    .LONG_PRESS_COUNTS (L),
    .ACTIVE_LOW        (1'b1)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .button          (button),
    .button_state    (button_state),
    .button_pressed  (button_pressed),
    .button_released (button_released),
    .button_held     (button_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // A level change is accepted once the synchronised input has disagreed
  // with the accepted level on D+1 consecutive edges. Held fires when the
  // number of edges since the accepted press reaches L.
  logic [15:0]   exp_q[$];
  logic [NB-1:0] m_s1, m_s2, m_act, m_lvl, m_pr, m_rl, m_hd;
  int            m_run[NB];
  int            m_age[NB];

  initial begin
    m_s1 = '0; m_s2 = '0; m_lvl = '0;
    for (int i = 0; i < NB; i++) begin
      m_run[i] = 0;
      m_age[i] = 0;
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0;
      for (int i = 0; i < NB; i++) begin
        m_run[i] = 0;
        m_age[i] = 0;
      end
      exp_q.push_back(16'h0000);
    end else begin
      m_act = m_s2;
      m_s2  = m_s1;
      m_s1  = ~button;
      m_pr = '0; m_rl = '0; m_hd = '0;
      for (int i = 0; i < NB; i++) begin
        if (m_lvl[i]) begin
          m_age[i] = m_age[i] + 1;
          if (m_age[i] == L) m_hd[i] = 1'b1;
        end
        if (m_act[i] != m_lvl[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == D + 1) begin
            m_lvl[i] = m_act[i];
            m_run[i] = 0;
            if (m_act[i]) begin
              m_pr[i]  = 1'b1;
              m_age[i] = 0;
            end else begin
              m_rl[i] = 1'b1;
            end
          end
        end else begin
          m_run[i] = 0;
        end
      end
      exp_q.push_back({m_lvl, m_pr, m_rl, m_hd});
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [15:0] got;
    logic [15:0] expv;
    got = {button_state, button_pressed, button_released, button_held};
    checks = checks + 1;
    if (exp_q.size() == 0) begin
      errors = errors + 1;
      $display("FAIL scoreboard_empty t=%0t got=%h expected=<entry>", $time, got);
    end else begin
      expv = exp_q.pop_front();
      if (!rst_n) expv = 16'h0000;
      if (got !== expv) begin
        errors = errors + 1;
        $display("FAIL scoreboard t=%0t got state/pr/rl/hd=%h expected=%h",
                 $time, got, expv);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drive(input logic [NB-1:0] b, input int n);
    button = b;
    wait_cycles(n);
  endtask

  // Asynchronous reset: outputs must clear without waiting for an edge.
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    #1;
    checks = checks + 1;
    if ({button_state, button_pressed, button_released, button_held} !== 16'h0000) begin
      errors = errors + 1;
      $display("FAIL async_reset t=%0t got=%h expected=0000", $time,
               {button_state, button_pressed, button_released, button_held});
    end
    wait_cycles(n);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic int pick_run();
    case ($urandom_range(0, 3))
      0:       return $urandom_range(1, 3);
      1:       return $urandom_range(3, 7);
      2:       return $urandom_range(8, 20);
      default: return $urandom_range(20, 40);
    endcase
  endfunction

  initial begin
    int            runlen[NB];
    logic [NB-1:0] b;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    button = 4'hF;
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(5);

    // clean press on channel 0, then release
    drive(4'b1110, 25);
    drive(4'b1111, 12);
    // bounce on channel 1
    drive(4'b1101, 2);
    drive(4'b1111, 1);
    drive(4'b1101, 2);
    drive(4'b1111, 12);
    // long hold on channel 2
    drive(4'b1011, 30);
    drive(4'b1111, 15);
    // release bounce on channel 0 while pressed
    drive(4'b1110, 12);
    drive(4'b1111, 2);
    drive(4'b1110, 20);
    drive(4'b1111, 15);
    // all channels simultaneously
    drive(4'b0000, 10);
    drive(4'b1111, 12);
    // reset during press debounce with the button held through it
    drive(4'b1110, 3);
    do_reset(2);
    drive(4'b1110, 15);
    drive(4'b1111, 12);

    // randomized runs: glitches, near-threshold, normal and long presses
    b = button;
    for (int i = 0; i < NB; i++) runlen[i] = pick_run();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NB; i++) begin
        if (runlen[i] == 0) begin
          b[i]      = ~b[i];
          runlen[i] = pick_run();
        end
        runlen[i] = runlen[i] - 1;
      end
      button = b;
      if ($urandom_range(0, 999) == 0) do_reset(2);
      else wait_cycles(1);
    end

    drive(4'hF, 20);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_debounce_multi
`default_nettype wire
